// File: rtl/divider_pkg.sv
// ============================================================================
//  divider_pkg : shared FSM encoding and sizing helpers for restoring_divider
//  Rev 1.0
// ============================================================================
`default_nettype none

package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Iteration counter width for a given operand width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

endpackage

`default_nettype wire

// File: rtl/trial_subtractor.sv
// ============================================================================
//  trial_subtractor : ripple a + ~b + 1, no_borrow is the final carry-out
//  Rev 1.0
// ============================================================================
`default_nettype none

module trial_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  logic [N:0] w_carry;

  assign w_carry[0] = 1'b1;

  generate
    for (genvar i = 0; i < N; i++) begin : g_bit
      logic w_bn;
      logic w_p;
      assign w_bn          = ~b[i];
      assign w_p           = a[i] ^ w_bn;
      assign diff[i]       = w_p ^ w_carry[i];
      assign w_carry[i+1]  = (a[i] & w_bn) | (w_carry[i] & w_p);
    end
  endgenerate

  assign no_borrow = w_carry[N];

endmodule

`default_nettype wire

// File: rtl/restoring_divider.sv
// ============================================================================
//  restoring_divider : sequential unsigned A/B, one quotient bit per cycle
//  Rev 1.0
// ============================================================================
`default_nettype none

module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W       = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [WIDTH:0]     w_trial_a;
  logic [WIDTH:0]     w_trial_b;
  logic [WIDTH:0]     w_diff;
  logic               w_no_borrow;

  // Shifted partial remainder against the zero-extended divisor.
  assign w_trial_a = {p_q, q_q[WIDTH-1]};
  assign w_trial_b = {1'b0, div_q};

  trial_subtractor #(
    .N(WIDTH + 1)
  ) u_trial_subtractor (
    .a        (w_trial_a),
    .b        (w_trial_b),
    .diff     (w_diff),
    .no_borrow(w_no_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      q_q        <= '0;
      div_q      <= '0;
      dbz_pend_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      q_q        <= q_d;
      div_q      <= div_d;
      dbz_pend_q <= dbz_pend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    q_d        = q_q;
    div_d      = div_q;
    dbz_pend_d = dbz_pend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // DONE publishes the finished result; done rises on the next cycle.
        if (state_q == DONE) begin
          quot_d  = q_q;
          rem_d   = p_q;
          dbz_d   = dbz_pend_q;
          done_d  = 1'b1;
        end
        state_d = IDLE;
        if (start) begin
          if (state_q == IDLE) begin
            dbz_d = 1'b0;
          end
          div_d = divisor;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d    = DONE;
            p_d        = dividend;
            q_d        = '1;
            dbz_pend_d = 1'b1;
          end else begin
            state_d    = RUN;
            p_d        = '0;
            q_d        = dividend;
            dbz_pend_d = 1'b0;
          end
        end
      end

      RUN: begin
        if (w_no_borrow) begin
          p_d = w_diff[WIDTH-1:0];
        end else begin
          p_d = w_trial_a[WIDTH-1:0];
        end
        q_d   = {q_q[WIDTH-2:0], w_no_borrow};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == c_LAST_ITER) begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_d      = (state_d == RUN);

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider.sv
// ============================================================================
//  tb_restoring_divider : scoreboard bench for restoring_divider (WIDTH=8)
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           issue;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: pops one expected result per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 with quotient=%0d, required no done", quotient);
      end else begin
        e = sb.pop_front();
        chk($sformatf("quotient %0d/%0d", e.a, e.b), 32'(quotient), 32'(e.q));
        chk($sformatf("remainder %0d/%0d", e.a, e.b), 32'(remainder), 32'(e.r));
        chk($sformatf("div_by_zero %0d/%0d", e.a, e.b), 32'(div_by_zero), 32'(e.dbz));
        chk($sformatf("latency %0d/%0d", e.a, e.b), 32'(cyc - e.issue), 32'(e.lat));
        if (e.b != 0) begin
          chk("identity q*d+r", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
          chk("rem_lt_divisor", 32'(remainder < e.b), 32'd1);
        end
      end
    end
  end

  // Drive start during the current low phase; sampled at the next rising edge.
  task automatic issue_now(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (expect_it) begin
      e.q = eq; e.r = er; e.dbz = edz; e.a = a; e.b = b;
      e.issue = cyc + 1;
      e.lat   = (b == 0) ? 1 : W + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz);
    @(negedge clk);
    issue_now(a, b, expect_it, eq, er, edz);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s: timeout, outstanding results %0d, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset quotient", 32'(quotient), 0);
    chk("reset remainder", 32'(remainder), 0);
    chk("reset div_by_zero", 32'(div_by_zero), 0);

    issue(8'd200, 8'd7, 1, 8'd28, 8'd4, 0);
    chk("busy after start", 32'(busy), 1);
    drain("200/7");
    issue(8'd255, 8'd1, 1, 8'd255, 8'd0, 0);
    drain("255/1");
    issue(8'd5, 8'd9, 1, 8'd0, 8'd5, 0);
    drain("5/9");

    issue(8'd150, 8'd0, 1, 8'd255, 8'd150, 1);
    drain("150/0");
    chk("div_by_zero held", 32'(div_by_zero), 1);
    issue(8'd255, 8'd255, 1, 8'd1, 8'd0, 0);
    chk("div_by_zero cleared by start", 32'(div_by_zero), 0);
    chk("quotient held while busy", 32'(quotient), 255);
    drain("255/255");

    // Second start at cycle 4 lands while busy and must be ignored.
    issue(8'd100, 8'd3, 1, 8'd33, 8'd1, 0);
    repeat (2) @(negedge clk);
    issue(8'd9, 8'd2, 0, 8'd0, 8'd0, 0);
    drain("100/3 with ignored 9/2");

    issue(8'd200, 8'd7, 0, 8'd0, 8'd0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun reset busy", 32'(busy), 0);
    chk("midrun reset done", 32'(done), 0);
    chk("midrun reset quotient", 32'(quotient), 0);
    chk("midrun reset remainder", 32'(remainder), 0);
    chk("midrun reset div_by_zero", 32'(div_by_zero), 0);
    issue(8'd50, 8'd5, 1, 8'd10, 8'd0, 0);
    drain("50/5 after reset");

    // Back-to-back: hold start during the done cycle.
    issue(8'd200, 8'd7, 1, 8'd28, 8'd4, 0);
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("done seen for b2b", 32'(done), 1);
    issue_now(8'd77, 8'd8, 1, 8'd9, 8'd5, 0);
    drain("b2b 77/8");

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      issue(ra, rb, 1, ra / rb, ra % rb, 0);
      drain("random sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
